recover_arbiter: RTL

//  Shares one compressed-to-uncompressed check-node recovery datapath (LAT-cycle

---
 rtl/recover_arbiter_pkg.sv | 22 ++
 rtl/recover_result_fifo.sv | 73 +++++++
 rtl/recover_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/recover_arbiter_pkg.sv
// Shared sizing for the check-node recovery path: the same values are used by the
// recovery datapath, the layer controller and this arbiter.
package recover_arbiter_pkg;

    localparam int Wc          = 32;
    localparam int Wcbits      = 5;
    localparam int W           = 10;
    localparam int ECOMPSIZE   = 2 * (W - 1) + Wcbits + Wc;
    localparam int EUNCOMPSIZE = Wc * W;
    localparam int LAT         = 3;
    localparam int DEPTH       = 4;
    localparam int CNTW        = $clog2(DEPTH + 1);

    // One shadow pipeline slot: tracks which requester owns a datapath stage.
    typedef struct packed {
        logic vld;
        logic id;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{vld: 1'b0, id: 1'b0};

endpackage

// File: rtl/recover_result_fifo.sv
// Per-requester result FIFO with wrap-around pointers and an occupancy count that
// feeds the arbiter's credit check.
module recover_result_fifo
    import recover_arbiter_pkg::*;
#(
    parameter int N_ENTRIES = DEPTH,
    parameter int DW        = EUNCOMPSIZE,
    parameter int CW        = $clog2(N_ENTRIES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] count
);

    localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    logic [DW-1:0] mem_q [N_ENTRIES];
    logic [DW-1:0] mem_d [N_ENTRIES];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // The arbiter's credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (push && (count_q == CW'(N_ENTRIES))) |-> pop)
        else $error("recover_result_fifo: push while full");

endmodule

// File: rtl/recover_arbiter.sv
// Round-robin issue of two recovery requesters onto one fixed-latency datapath,
// with a shadow pipe tagging in-flight slots and credit-limited result FIFOs.
module recover_arbiter
    import recover_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [ECOMPSIZE-1:0]   req0_ecomp,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [ECOMPSIZE-1:0]   req1_ecomp,
    output logic [ECOMPSIZE-1:0]   dp_ecomp,
    input  logic [EUNCOMPSIZE-1:0] dp_euncomp,
    output logic                   res0_valid,
    input  logic                   res0_ready,
    output logic [EUNCOMPSIZE-1:0] res0_data,
    output logic                   res1_valid,
    input  logic                   res1_ready,
    output logic [EUNCOMPSIZE-1:0] res1_data,
    output logic                   busy
);

    localparam int CW1 = CNTW + 1;
    localparam logic [CW1-1:0] CREDIT_MAX = CW1'(DEPTH);

    slot_t           shadow_q [LAT];
    slot_t           shadow_d [LAT];
    logic            ptr_q, ptr_d;
    logic [CNTW-1:0] inflight0_q, inflight0_d;
    logic [CNTW-1:0] inflight1_q, inflight1_d;
    logic [CNTW-1:0] count0, count1;
    logic [CW1-1:0]  used0, used1;
    logic            elig0, elig1;
    logic            grant0, grant1, grant_any;
    logic            retire, push0, push1;
    logic            shadow_busy;

    always_comb begin
        // A requester may only issue if its result is guaranteed a FIFO slot.
        used0 = {1'b0, inflight0_q} + {1'b0, count0};
        used1 = {1'b0, inflight1_q} + {1'b0, count1};
        elig0 = req0_valid && (used0 < CREDIT_MAX);
        elig1 = req1_valid && (used1 < CREDIT_MAX);

        grant0    = elig0 && (!elig1 || (ptr_q == 1'b0));
        grant1    = elig1 && (!elig0 || (ptr_q == 1'b1));
        grant_any = grant0 || grant1;

        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end

        dp_ecomp = '0;
        if (grant0) begin
            dp_ecomp = req0_ecomp;
        end else if (grant1) begin
            dp_ecomp = req1_ecomp;
        end

        retire = shadow_q[LAT-1].vld;
        push0  = retire && !shadow_q[LAT-1].id;
        push1  = retire &&  shadow_q[LAT-1].id;

        shadow_d[0] = '{vld: grant_any, id: grant1};
        for (int i = 1; i < LAT; i++) begin
            shadow_d[i] = shadow_q[i-1];
        end

        inflight0_d = inflight0_q + CNTW'(grant0) - CNTW'(push0);
        inflight1_d = inflight1_q + CNTW'(grant1) - CNTW'(push1);

        shadow_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            shadow_busy = shadow_busy | shadow_q[i].vld;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                shadow_q[i] <= SLOT_IDLE;
            end
            ptr_q       <= 1'b0;
            inflight0_q <= '0;
            inflight1_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            ptr_q       <= ptr_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
        end
    end

    recover_result_fifo #(
        .N_ENTRIES (DEPTH),
        .DW        (EUNCOMPSIZE),
        .CW        (CNTW)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (dp_euncomp),
        .pop       (res0_ready),
        .rd_valid  (res0_valid),
        .rd_data   (res0_data),
        .count     (count0)
    );

    recover_result_fifo #(
        .N_ENTRIES (DEPTH),
        .DW        (EUNCOMPSIZE),
        .CW        (CNTW)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (dp_euncomp),
        .pop       (res1_ready),
        .rd_valid  (res1_valid),
        .rd_data   (res1_data),
        .count     (count1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = shadow_busy | (count0 != '0) | (count1 != '0);

endmodule
